pursuit_correlator: RTL and testbench
=====================================

Name: pursuit_correlator

Overview:
- Matching-pursuit correlation stage. Consumes signal/residual y and dictionary D over read-only memory ports; produces c[j] = sum_i D[i,j]*y[i] for every atom j, plus the argmax of |c[j]|.
- Sits upstream of the support-selection/representation update stage, which consumes the per-atom stream and the winning index.
- Start/busy/done handshake; one multiply-accumulate per clock.

Parameters:
- SIGNAL_SIZE, 64 (SIGNAL_SIZE_DEFAULT), M: samples per atom, >=2.
- DICTIONARY_SIZE, 256 (DICTIONARY_SIZE_DEFAULT), N: atoms, >=2.
- ACC_WIDTH, 32 (FP_N_DEFAULT), accumulator/correlation width, signed.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of pass.
- y_read_addr  out  SIGNAL_ADDR_WIDTH  sample index i.
- y_read_data  in  DATA_BUS_WIDTH  signed int8 y[i], valid one cycle after address.
- dict_read_addr  out  DICTIONARY_ADDR_WIDTH  j*M+i, column-major.
- dict_read_data  in  DATA_BUS_WIDTH  signed int8 D[i,j], valid one cycle after address.
- corr_valid  out  1  one-cycle strobe per atom.
- corr_index  out  REPRESENTATION_ADDR_WIDTH  atom j for current strobe.
- corr_value  out  ACC_WIDTH  signed c[j].
- best_index  out  REPRESENTATION_ADDR_WIDTH  argmax |c|, final at done.
- best_value  out  ACC_WIDTH  signed c at best_index (sign kept).

Behaviour:
- Reset values: all outputs 0; state IDLE; counters i, j = 0.
- States:
  - IDLE: start=1 -> RUN; start=0 -> stay.
  - RUN: issue one (i,j) address pair per cycle, i fastest. After the last pair (i=M-1, j=N-1) -> FLUSH.
  - FLUSH: 2 cycles draining the pipeline -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start is ignored outside IDLE.
  - A start held high through DONE begins a new pass from IDLE in the following cycle.
- Timing, with start sampled in cycle 0:
  - Addresses presented in cycles 1..N*M.
  - Data for an address presented in cycle k is used in cycle k+1: acc <= (i==0 ? 0 : acc) + sext(y)*sext(D).
  - corr_valid for atom j is high in cycle c+2, where c is the cycle of its i=M-1 address.
  - Last corr_valid in cycle N*M+2; done in cycle N*M+3; busy high in cycles 1..N*M+3.
- Arithmetic:
  - 8x8 signed product = 16 bits, sign-extended to ACC_WIDTH.
  - M*2^14 must fit in ACC_WIDTH, so no saturation logic.
  - |x| uses ACC_WIDTH+1 bits so that -2^(ACC_WIDTH-1) is safe.
- Argmax:
  - Atom 0 initialises best unconditionally.
  - Later atoms replace best only if |c| strictly greater, so ties keep the lowest index.
  - best_* update on the same edge corr_valid rises and hold until the next pass's atom 0.
- Address ports hold their last value outside RUN. No write ports; memories are read-only to this block.
- Reset mid-pass: state IDLE next cycle, all outputs 0, no done and no further corr_valid. Partial results are discarded.

Decomposition:
- Shared package additions:
  - CORR_ACC_WIDTH = FP_N_DEFAULT.
  - pursuit_corr_state_t enum {IDLE, RUN, FLUSH, DONE}.
  - Typedefs pursuit_corr_t (signed ACC_WIDTH) and pursuit_sample_t (signed DATA_BUS_WIDTH).
- One natural sub-module: pursuit_mac.
  - Registered signed 8x8 multiply-accumulate with synchronous clear-on-first and a valid-in/valid-out pipeline bit.
  - Reused later by the residual-update stage.
- The FSM, counters and argmax stay in pursuit_correlator.

Test Plan (M=4, N=3 unless noted; memory model with 1-cycle read latency):
- y=[1,2,3,4]; D columns [1,1,1,1],[0,0,0,1],[-2,-2,-2,-2] -> corr stream 10, 4, -20 in cycles 6, 10, 14; best_index=2, best_value=-20; done in cycle 15; busy high cycles 1..15.
- Tie: columns giving c=[5,-5,5] -> best_index=0, best_value=5.
- Extreme values: y all -128, D column 1 all -128 (others 0) -> c[1]=65536, best_index=1; also with M=64 all -128 -> 1048576 exact.
- start pulsed in cycles 3 and 8 during a pass -> ignored; exactly 3 corr_valid strobes and one done.
- reset asserted in cycle 7 -> cycle 8: busy=0, corr_valid=0, best_*=0; a new start then runs to the normal result with no residue from the aborted pass.
- start held high continuously -> second pass begins in the cycle after DONE's IDLE cycle; both passes report identical streams.

Source files
------------

// File: rtl/pursuit_correlator_pkg.sv
// Shared types and defaults for the matching-pursuit correlation stage and
// the MAC it shares with the residual-update stage.
package pursuit_correlator_pkg;

  localparam int SIGNAL_SIZE_DEFAULT     = 64;
  localparam int DICTIONARY_SIZE_DEFAULT = 256;
  localparam int FP_N_DEFAULT            = 32;
  localparam int DATA_BUS_WIDTH          = 8;
  localparam int PRODUCT_WIDTH           = 2 * DATA_BUS_WIDTH;
  localparam int CORR_ACC_WIDTH          = FP_N_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } pursuit_corr_state_t;

  typedef logic signed [CORR_ACC_WIDTH-1:0] pursuit_corr_t;
  typedef logic signed [DATA_BUS_WIDTH-1:0] pursuit_sample_t;

endpackage

// File: rtl/pursuit_correlator_mac.sv
// Signed 8x8 multiply-accumulate; i_first restarts the sum, and o_valid
// strobes the cycle after the i_last term has been absorbed.
module pursuit_mac
  import pursuit_correlator_pkg::*;
#(
  parameter int ACC_WIDTH = CORR_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic                        i_first,
  input  logic                        i_last,
  input  pursuit_sample_t             i_a,
  input  pursuit_sample_t             i_b,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic signed [ACC_WIDTH-1:0] o_acc_next,
  output logic                        o_valid
);

  logic signed [PRODUCT_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]     r_acc;
  logic                            r_valid;

  assign w_prod = i_a * i_b;

  // o_acc_next is exposed so a consumer can act on the sum in the same edge it lands
  assign o_acc_next = (i_first ? '0 : r_acc)
                    + {{(ACC_WIDTH-PRODUCT_WIDTH){w_prod[PRODUCT_WIDTH-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid & i_last;
      if (i_valid) r_acc <= o_acc_next;
    end
  end

  assign o_acc   = r_acc;
  assign o_valid = r_valid;

endmodule

// File: rtl/pursuit_correlator.sv
// Correlates y against every dictionary atom (one MAC per clock) and tracks
// the atom with the largest |c|, lowest index winning ties.
module pursuit_correlator
  import pursuit_correlator_pkg::*;
#(
  parameter  int SIGNAL_SIZE               = SIGNAL_SIZE_DEFAULT,
  parameter  int DICTIONARY_SIZE           = DICTIONARY_SIZE_DEFAULT,
  parameter  int ACC_WIDTH                 = FP_N_DEFAULT,
  localparam int SIGNAL_ADDR_WIDTH         = $clog2(SIGNAL_SIZE),
  localparam int DICTIONARY_ADDR_WIDTH     = $clog2(SIGNAL_SIZE * DICTIONARY_SIZE),
  localparam int REPRESENTATION_ADDR_WIDTH = $clog2(DICTIONARY_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [SIGNAL_ADDR_WIDTH-1:0]         y_read_addr,
  input  logic [DATA_BUS_WIDTH-1:0]            y_read_data,
  output logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_read_addr,
  input  logic [DATA_BUS_WIDTH-1:0]            dict_read_data,
  output logic                                 corr_valid,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] corr_index,
  output logic signed [ACC_WIDTH-1:0]          corr_value,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] best_index,
  output logic signed [ACC_WIDTH-1:0]          best_value
);

  localparam logic [SIGNAL_ADDR_WIDTH-1:0]         I_LAST = SIGNAL_ADDR_WIDTH'(SIGNAL_SIZE - 1);
  localparam logic [REPRESENTATION_ADDR_WIDTH-1:0] J_LAST = REPRESENTATION_ADDR_WIDTH'(DICTIONARY_SIZE - 1);

  pursuit_corr_state_t                  r_state;
  logic [SIGNAL_ADDR_WIDTH-1:0]         r_i;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] r_j;
  logic [DICTIONARY_ADDR_WIDTH-1:0]     r_daddr;
  logic                                 r_flush;
  logic                                 r_busy;
  logic                                 r_done;

  logic                                 r_d_valid;
  logic                                 r_d_first;
  logic                                 r_d_last;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] r_d_j;

  logic [REPRESENTATION_ADDR_WIDTH-1:0] r_corr_index;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] r_best_index;
  logic signed [ACC_WIDTH-1:0]          r_best_value;

  logic signed [ACC_WIDTH-1:0]          w_acc;
  logic signed [ACC_WIDTH-1:0]          w_acc_next;
  logic                                 w_corr_valid;
  logic [ACC_WIDTH:0]                   w_ext_next;
  logic [ACC_WIDTH:0]                   w_abs_next;
  logic [ACC_WIDTH:0]                   w_ext_best;
  logic [ACC_WIDTH:0]                   w_abs_best;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_daddr <= '0;
      r_flush <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
            r_daddr <= '0;
          end
        end
        RUN: begin
          // addresses freeze on the final pair so they hold outside RUN
          if (r_i == I_LAST) begin
            if (r_j == J_LAST) begin
              r_state <= FLUSH;
              r_flush <= 1'b0;
            end else begin
              r_i     <= '0;
              r_j     <= r_j + REPRESENTATION_ADDR_WIDTH'(1);
              r_daddr <= r_daddr + DICTIONARY_ADDR_WIDTH'(1);
            end
          end else begin
            r_i     <= r_i + SIGNAL_ADDR_WIDTH'(1);
            r_daddr <= r_daddr + DICTIONARY_ADDR_WIDTH'(1);
          end
        end
        FLUSH: begin
          if (r_flush) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_flush <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tags travel one cycle behind the address to line up with the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_valid <= 1'b0;
      r_d_first <= 1'b0;
      r_d_last  <= 1'b0;
      r_d_j     <= '0;
    end else begin
      r_d_valid <= (r_state == RUN);
      r_d_first <= (r_i == '0);
      r_d_last  <= (r_i == I_LAST);
      r_d_j     <= r_j;
    end
  end

  pursuit_mac #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (r_d_valid),
    .i_first   (r_d_first),
    .i_last    (r_d_last),
    .i_a       (y_read_data),
    .i_b       (dict_read_data),
    .o_acc     (w_acc),
    .o_acc_next(w_acc_next),
    .o_valid   (w_corr_valid)
  );

  // One extra bit keeps |-2^(ACC_WIDTH-1)| representable.
  assign w_ext_next = {w_acc_next[ACC_WIDTH-1], w_acc_next};
  assign w_abs_next = w_ext_next[ACC_WIDTH] ? -w_ext_next : w_ext_next;
  assign w_ext_best = {r_best_value[ACC_WIDTH-1], r_best_value};
  assign w_abs_best = w_ext_best[ACC_WIDTH] ? -w_ext_best : w_ext_best;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_corr_index <= '0;
      r_best_index <= '0;
      r_best_value <= '0;
    end else if (r_d_valid && r_d_last) begin
      r_corr_index <= r_d_j;
      if (r_d_j == '0 || w_abs_next > w_abs_best) begin
        r_best_index <= r_d_j;
        r_best_value <= w_acc_next;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign y_read_addr    = r_i;
  assign dict_read_addr = r_daddr;
  assign corr_valid     = w_corr_valid;
  assign corr_index     = r_corr_index;
  assign corr_value     = w_acc;
  assign best_index     = r_best_index;
  assign best_value     = r_best_value;

endmodule

// File: tb/tb_pursuit_correlator.sv
// Directed bench: timing/value model derived from the pass schedule, with
// literal expectations for the hand-worked cases.
module tb_pursuit_correlator;
  localparam int M  = 4;
  localparam int N  = 3;
  localparam int P  = N * M + 4;
  localparam int M2 = 64;
  localparam int N2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic               busy, done, cv;
  logic [1:0]         y_addr;
  logic [3:0]         d_addr;
  logic [7:0]         y_data, d_data;
  logic [1:0]         cidx, bidx;
  logic signed [31:0] cval, bval;

  logic               busy2, done2, cv2;
  logic [5:0]         y_addr2;
  logic [6:0]         d_addr2;
  logic [7:0]         y_data2, d_data2;
  logic               cidx2, bidx2;
  logic signed [31:0] cval2, bval2;

  logic signed [7:0] y_mem [4];
  logic signed [7:0] d_mem [16];

  pursuit_correlator #(.SIGNAL_SIZE(M), .DICTIONARY_SIZE(N), .ACC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .y_read_addr(y_addr), .y_read_data(y_data),
    .dict_read_addr(d_addr), .dict_read_data(d_data),
    .corr_valid(cv), .corr_index(cidx), .corr_value(cval),
    .best_index(bidx), .best_value(bval));

  pursuit_correlator #(.SIGNAL_SIZE(M2), .DICTIONARY_SIZE(N2), .ACC_WIDTH(32)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .y_read_addr(y_addr2), .y_read_data(y_data2),
    .dict_read_addr(d_addr2), .dict_read_data(d_data2),
    .corr_valid(cv2), .corr_index(cidx2), .corr_value(cval2),
    .best_index(bidx2), .best_value(bval2));

  always @(posedge clk) begin
    y_data  <= y_mem[y_addr];
    d_data  <= d_mem[d_addr];
    y_data2 <= 8'h80;
    d_data2 <= 8'h80;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int m_c [N];
  int m_best_idx, m_best_val;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model();
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < M; i++) s += int'(y_mem[i]) * int'(d_mem[j*M+i]);
      m_c[j] = s;
      if (j == 0 || iabs(s) > iabs(m_best_val)) begin
        m_best_idx = j;
        m_best_val = s;
      end
    end
  endfunction

  task automatic load(input int y0, y1, y2, y3, input int d [12]);
    y_mem[0] = 8'(y0); y_mem[1] = 8'(y1); y_mem[2] = 8'(y2); y_mem[3] = 8'(y3);
    for (int k = 0; k < 12; k++) d_mem[k] = 8'(d[k]);
    for (int k = 12; k < 16; k++) d_mem[k] = 8'sd0;
  endtask

  int  t0 = 0;
  bit  chk_on = 1'b0;
  int  n_cv = 0;
  int  n_done = 0;

  // Pass schedule: addresses in 1..N*M, atom j strobes at M*(j+1)+2, done at N*M+3.
  always @(negedge clk) begin : cmp
    int rel, r, j;
    logic eb, ed, ecv;
    if (chk_on) begin
      rel = cyc - t0;
      r   = (rel == 0) ? 0 : ((rel - 1) % P) + 1;
      eb  = (r >= 1 && r <= N*M + 3);
      ed  = (r == N*M + 3);
      ecv = (r >= M + 2) && ((r - 2) % M == 0) && (r <= N*M + 2);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("corr_valid", cv, ecv);
      if (cv) n_cv++;
      if (done) n_done++;
      if (ecv) begin
        j = (r - 2) / M - 1;
        chk("corr_index", cidx, j);
        chk("corr_value", cval, m_c[j]);
      end
      if (ed) begin
        chk("best_index", bidx, m_best_idx);
        chk("best_value", bval, m_best_val);
      end
    end
  end

  task automatic run(input int npass, input bit hold, input int pa, input int pb);
    model();
    n_cv = 0;
    n_done = 0;
    @(negedge clk);
    t0 = cyc;
    chk_on = 1'b1;
    start = 1'b1;
    for (int rel = 1; rel <= npass * P; rel++) begin
      @(negedge clk);
      start = (hold && rel <= (npass - 1) * P) || rel == pa || rel == pb;
    end
    chk_on = 1'b0;
    start = 1'b0;
    chk("strobe_count", n_cv, N * npass);
    chk("done_count", n_done, npass);
  endtask

  int dcols_a [12] = '{1, 1, 1, 1, 0, 0, 0, 1, -2, -2, -2, -2};
  int dcols_t [12] = '{5, 0, 0, 0, -5, 0, 0, 0, 5, 0, 0, 0};
  int dcols_x [12] = '{0, 0, 0, 0, -128, -128, -128, -128, 0, 0, 0, 0};

  initial begin
    int cnt, cnt_d;
    bit seen;
    load(0, 0, 0, 0, dcols_a);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_corr_valid", cv, 0);
    chk("rst_corr_value", cval, 0);
    chk("rst_best_index", bidx, 0);
    chk("rst_best_value", bval, 0);
    chk("rst_y_addr", y_addr, 0);
    chk("rst_dict_addr", d_addr, 0);
    chk("rst_busy2", busy2, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    load(1, 2, 3, 4, dcols_a);
    run(1, 1'b0, -1, -1);
    chk("model_c0", m_c[0], 10);
    chk("model_c1", m_c[1], 4);
    chk("model_c2", m_c[2], -20);
    chk("basic_best_index", bidx, 2);
    chk("basic_best_value", bval, -20);
    chk("hold_y_addr", y_addr, M - 1);
    chk("hold_dict_addr", d_addr, N * M - 1);

    load(1, 2, 3, 4, dcols_t);
    run(1, 1'b0, -1, -1);
    chk("tie_best_index", bidx, 0);
    chk("tie_best_value", bval, 5);

    load(-128, -128, -128, -128, dcols_x);
    run(1, 1'b0, -1, -1);
    chk("ext_model_c1", m_c[1], 65536);
    chk("ext_best_index", bidx, 1);
    chk("ext_best_value", bval, 65536);

    load(1, 2, 3, 4, dcols_a);
    run(1, 1'b0, 3, 8);
    chk("pulse_best_value", bval, -20);

    // abort a pass with reset in cycle 7
    model();
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    for (int rel = 1; rel <= 7; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (rel == 6) chk("abort_pre_cv", cv, 1);
    end
    chk("abort_pre_best", bval, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_corr_valid", cv, 0);
    chk("abort_done", done, 0);
    chk("abort_best_index", bidx, 0);
    chk("abort_best_value", bval, 0);
    cnt = 0;
    cnt_d = 0;
    repeat (20) begin
      @(negedge clk);
      if (cv) cnt++;
      if (done || busy) cnt_d++;
    end
    chk("abort_quiet_cv", cnt, 0);
    chk("abort_quiet_busy_done", cnt_d, 0);
    run(1, 1'b0, -1, -1);
    chk("after_abort_best_index", bidx, 2);
    chk("after_abort_best_value", bval, -20);

    load(1, 2, 3, 4, dcols_t);
    run(2, 1'b1, -1, -1);
    chk("held_best_index", bidx, 0);

    // M=64 all -128: each atom sums to 64*16384
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (cv2) begin
        cnt++;
        chk("m64_corr_value", cval2, 1048576);
      end
      if (done2) seen = 1'b1;
    end
    chk("m64_done_seen", seen, 1);
    chk("m64_strobes", cnt, N2);
    chk("m64_best_index", bidx2, 0);
    chk("m64_best_value", bval2, 1048576);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
